sc_phase_sequencer: RTL



---
 rtl/sc_phase_sequencer_if.sv | 37 +++
 rtl/sc_phase_sequencer.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/sc_phase_sequencer_if.sv
// Bundle of run/config inputs and switch-drive outputs of sc_phase_sequencer.
// Optional early-phase signals exist only when SC_EARLY_PHASE_EN is defined.
interface sc_phase_sequencer_if #(
    parameter int NUM_CH = 2,
    parameter int DIV_W  = 8,
    parameter int DEAD_W = 4
);
    logic              en;
    logic [DIV_W-1:0]  div;
    logic [DEAD_W-1:0] dead;
    logic [NUM_CH-1:0] ch_en;
    logic [NUM_CH-1:0] phi1;
    logic [NUM_CH-1:0] phi2;
    logic              cycle_done;
    logic              busy;
    logic              cfg_err;
`ifdef SC_EARLY_PHASE_EN
    logic [NUM_CH-1:0] phi1e;
    logic [NUM_CH-1:0] phi2e;
`endif

    modport master (
        output en, div, dead, ch_en,
`ifdef SC_EARLY_PHASE_EN
        input  phi1e, phi2e,
`endif
        input  phi1, phi2, cycle_done, busy, cfg_err
    );

    modport slave (
        input  en, div, dead, ch_en,
`ifdef SC_EARLY_PHASE_EN
        output phi1e, phi2e,
`endif
        output phi1, phi2, cycle_done, busy, cfg_err
    );
endinterface

// File: rtl/sc_phase_sequencer.sv
// Multi-channel two-phase non-overlapping clock sequencer for switched-cap banks.
// Define SC_EARLY_PHASE_EN to add early-falling phi1e/phi2e bottom-plate drives.
module sc_phase_sequencer #(
    parameter int NUM_CH = 2,
    parameter int DIV_W  = 8,
    parameter int DEAD_W = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    sc_phase_sequencer_if.slave    bus
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_PHI1   = 3'd1;
    localparam logic [2:0] S_DEAD12 = 3'd2;
    localparam logic [2:0] S_PHI2   = 3'd3;
    localparam logic [2:0] S_DEAD21 = 3'd4;

    // Dead-time reload value: an illegal zero is treated as one cycle.
    function automatic logic [DEAD_W-1:0] dead_load(input logic [DEAD_W-1:0] d);
        return (d == '0) ? '0 : d - DEAD_W'(1);
    endfunction

    logic [2:0]        state_q, state_d;
    logic [DIV_W-1:0]  phase_cnt_q, phase_cnt_d;
    logic [DEAD_W-1:0] dead_cnt_q, dead_cnt_d;
    logic [DIV_W-1:0]  div_sh_q, div_sh_d;
    logic [DEAD_W-1:0] dead_sh_q, dead_sh_d;
    logic [NUM_CH-1:0] ch_en_sh_q, ch_en_sh_d;
    logic              cfg_err_q, cfg_err_d;
    logic [NUM_CH-1:0] phi1_q, phi1_d;
    logic [NUM_CH-1:0] phi2_q, phi2_d;
    logic              cycle_done_q, cycle_done_d;
    logic              busy_q, busy_d;
    logic              latch;
    logic              bad_cfg;

`ifdef SC_EARLY_PHASE_EN
    logic [NUM_CH-1:0] phi1e_q, phi1e_d;
    logic [NUM_CH-1:0] phi2e_q, phi2e_d;

    // A one-cycle phase cannot fall early, so div==0 is flagged as well.
    assign bad_cfg = (bus.dead == '0) || (bus.div == '0);
`else
    assign bad_cfg = (bus.dead == '0);
`endif

    always_comb begin
        state_d     = state_q;
        phase_cnt_d = phase_cnt_q;
        dead_cnt_d  = dead_cnt_q;
        div_sh_d    = div_sh_q;
        dead_sh_d   = dead_sh_q;
        ch_en_sh_d  = ch_en_sh_q;
        cfg_err_d   = cfg_err_q;
        latch       = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (bus.en) latch = 1'b1;
            end
            S_PHI1: begin
                if (phase_cnt_q == '0) begin
                    state_d    = S_DEAD12;
                    dead_cnt_d = dead_load(dead_sh_q);
                end else begin
                    phase_cnt_d = phase_cnt_q - DIV_W'(1);
                end
            end
            S_DEAD12: begin
                if (dead_cnt_q == '0) begin
                    state_d     = S_PHI2;
                    phase_cnt_d = div_sh_q;
                end else begin
                    dead_cnt_d = dead_cnt_q - DEAD_W'(1);
                end
            end
            S_PHI2: begin
                if (phase_cnt_q == '0) begin
                    state_d    = S_DEAD21;
                    dead_cnt_d = dead_load(dead_sh_q);
                end else begin
                    phase_cnt_d = phase_cnt_q - DIV_W'(1);
                end
            end
            S_DEAD21: begin
                if (dead_cnt_q == '0) begin
                    if (bus.en) latch = 1'b1;
                    else        state_d = S_IDLE;
                end else begin
                    dead_cnt_d = dead_cnt_q - DEAD_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Config is sampled only here, so mid-cycle changes never disturb a running cycle.
        if (latch) begin
            state_d     = S_PHI1;
            div_sh_d    = bus.div;
            dead_sh_d   = bus.dead;
            ch_en_sh_d  = bus.ch_en;
            phase_cnt_d = bus.div;
            cfg_err_d   = cfg_err_q | bad_cfg;
        end
    end

    // Outputs are decoded from the next state so every drive is a plain flop.
    always_comb begin
        phi1_d       = (state_d == S_PHI1) ? ch_en_sh_d : '0;
        phi2_d       = (state_d == S_PHI2) ? ch_en_sh_d : '0;
        cycle_done_d = (state_d == S_DEAD21) && (dead_cnt_d == '0);
        busy_d       = (state_d != S_IDLE);
    end

`ifdef SC_EARLY_PHASE_EN
    always_comb begin
        phi1e_d = ((state_d == S_PHI1) && ((phase_cnt_d != '0) || (div_sh_d == '0)))
                  ? ch_en_sh_d : '0;
        phi2e_d = ((state_d == S_PHI2) && ((phase_cnt_d != '0) || (div_sh_d == '0)))
                  ? ch_en_sh_d : '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            phi1e_q <= '0;
            phi2e_q <= '0;
        end else begin
            phi1e_q <= phi1e_d;
            phi2e_q <= phi2e_d;
        end
    end

    assign bus.phi1e = phi1e_q;
    assign bus.phi2e = phi2e_q;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            phase_cnt_q  <= '0;
            dead_cnt_q   <= '0;
            cfg_err_q    <= 1'b0;
            phi1_q       <= '0;
            phi2_q       <= '0;
            cycle_done_q <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            phase_cnt_q  <= phase_cnt_d;
            dead_cnt_q   <= dead_cnt_d;
            cfg_err_q    <= cfg_err_d;
            phi1_q       <= phi1_d;
            phi2_q       <= phi2_d;
            cycle_done_q <= cycle_done_d;
            busy_q       <= busy_d;
        end
    end

    // Shadow config only matters outside IDLE, and is always written on the way out of it.
    always_ff @(posedge clk) begin
        div_sh_q   <= div_sh_d;
        dead_sh_q  <= dead_sh_d;
        ch_en_sh_q <= ch_en_sh_d;
    end

    assign bus.phi1       = phi1_q;
    assign bus.phi2       = phi2_q;
    assign bus.cycle_done = cycle_done_q;
    assign bus.busy       = busy_q;
    assign bus.cfg_err    = cfg_err_q;

    a_no_overlap: assert property (@(posedge clk) disable iff (rst) (phi1_q & phi2_q) == '0);
    a_idle_quiet: assert property (@(posedge clk) disable iff (rst)
                                   !busy_q |-> ((phi1_q == '0) && (phi2_q == '0)));

endmodule
